// File: rtl/bridge_pkg.sv
// Shared types, size codes, fixed AXI field values and byte-strobe helper
// for the SRAM-to-AXI bridge.
package bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_REQ = 3'd3,
    WR_B   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [ID_W-1:0]  AXI_ID         = '0;
  localparam logic [LEN_W-1:0] AXI_LEN        = '0;
  localparam logic [1:0]       AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]       AXI_LOCK       = 2'b00;
  localparam logic [3:0]       AXI_CACHE      = 4'b0000;
  localparam logic [2:0]       AXI_PROT       = 3'b000;

  // Byte lanes touched by an access; misaligned offsets simply shift lanes out.
  function automatic logic [STRB_W-1:0] wstrb_f(input logic [1:0] size,
                                                input logic [1:0] offs);
    logic [STRB_W-1:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << offs;
      SIZE_HALF: strb = 4'b0011 << offs;
      SIZE_WORD: strb = 4'b1111;
      default:   strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Single-outstanding bridge from an SRAM-like request port to an AXI master;
// accepts a new request in the completion cycle of the previous one.
module sram_axi_bridge
  import bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  // SRAM-like responder side
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  // AXI read address
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data and response
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  state_t            state, state_n;
  logic              aw_done, aw_done_n;
  logic              w_done, w_done_n;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;

  // Fixed single-beat INCR attributes
  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awid    = AXI_ID;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = AXI_ID;
  assign wlast   = 1'b1;

  // Payload comes only from the latched request, so it is stable while valid
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata_o = wdata_q;
  assign wstrb   = wstrb_f(size_q, addr_q[1:0]);
  assign rdata   = rdata_i;

  // Channel handshake signals decoded from registered state
  assign arvalid = (state == RD_AR);
  assign rready  = (state == RD_R);
  assign awvalid = (state == WR_REQ) && !aw_done;
  assign wvalid  = (state == WR_REQ) && !w_done;
  assign bready  = (state == WR_B);

  assign accept  = req && addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Request capture on every accepted handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= wr;
      size_q  <= size;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = req;
      end
      RD_AR: begin
        if (arready) state_n = RD_R;
      end
      RD_R: begin
        if (rvalid) begin
          data_ok = !wr_q;
          addr_ok = req;
          state_n = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W may complete in either order or together
        if (awvalid && awready) aw_done_n = 1'b1;
        if (wvalid && wready)   w_done_n  = 1'b1;
        if (aw_done_n && w_done_n) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          data_ok = wr_q;
          addr_ok = req;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (accept) state_n = wr ? WR_REQ : RD_AR;
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `resetn`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have these SRAM-like responder inputs: `req` 1, `wr` 1, `size` 2 (0 byte, 1 half, 2 word), `addr` 32, `wdata` 32.
REQ-004 SHALL have these SRAM-like responder outputs: `addr_ok` 1, `data_ok` 1, `rdata` 32.
REQ-005 SHALL have AXI read-address ports: `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1.
REQ-006 SHALL have AXI read-data ports: `rdata_i` in 32, `rvalid` in 1, `rready` out 1.
REQ-007 SHALL have AXI write-address ports: `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1.
REQ-008 SHALL have AXI write-data and response ports: `wdata_o` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1, `bvalid` in 1, `bready` out 1.
REQ-009 SHALL drive the fixed AXI fields as constants: ID 0, len 0, burst INCR, wlast 1, lock/cache/prot 0.

Function
REQ-010 SHALL keep at most one transaction outstanding, using FSM states IDLE, RD_AR, RD_R, WR_REQ, WR_B.
REQ-011 SHALL assert `addr_ok` = `req` && (IDLE || (RD_R && `rvalid`) || (WR_B && `bvalid`)), combinationally.
REQ-012 SHALL latch `addr`, `size`, `wdata` and `wr` on every cycle where `req` && `addr_ok`.
REQ-013 SHALL move to RD_AR on an accepted read and to WR_REQ on an accepted write, including acceptance in the completion cycle (back-to-back).
REQ-014 SHALL, in RD_AR: `arvalid`=1; on `arready` -> RD_R.
REQ-015 SHALL, in RD_R: `rready`=1; on `rvalid` -> `data_ok`=1 and `rdata`=`rdata_i` in that same cycle; next state is IDLE, or per REQ-013.
REQ-016 SHALL, in WR_REQ: `awvalid` and `wvalid` asserted together; aw_done and w_done are tracked independently, each valid drops after its own handshake; once both are done -> WR_B.
REQ-017 SHALL, in WR_B: `bready`=1; on `bvalid` -> `data_ok`=1; next state is IDLE, or per REQ-013.
REQ-018 SHALL hold `data_ok` at 0 in all other cycles; `data_ok` is a single-cycle pulse per transaction.
REQ-019 SHALL derive `arsize`/`awsize` as {1'b0, size}, with `araddr`/`awaddr` equal to the latched addr.
REQ-020 SHALL set `wstrb` as follows: size0 -> 4'b0001<<addr[1:0]; size1 -> 4'b0011<<addr[1:0]; size2 -> 4'b1111; size3 -> 4'b0000.
REQ-021 SHALL treat alignment as the CPU's responsibility: a misaligned request is passed through unchecked.
REQ-022 SHALL not drop `arvalid`/`awvalid`/`wvalid` before their handshake, and SHALL keep their payload stable while valid.
REQ-023 SHALL ignore `req` while busy (addr_ok=0) except in the completion cycle defined in REQ-011.

Reset
REQ-024 SHALL, while `resetn`=0: state IDLE, aw_done and w_done 0, all AXI valid/ready outputs 0, `data_ok` 0, latched registers 0.
REQ-025 SHALL abandon any in-flight transaction when reset is asserted mid-transaction, and SHALL issue no AXI valid in the first cycle after release.

Structure
REQ-026 SHALL take FSM state encodings, the size codes and the AXI constant fields from shared package `bridge_pkg`.
REQ-027 SHALL be a single module; `wstrb` generation is a function in `bridge_pkg`, with no sub-module.

Verification
REQ-028 SHALL cover word read: req=1, wr=0, addr=0x1000, size=2; arready on the next cycle; rvalid 2 cycles later with rdata_i=0xDEADBEEF -> addr_ok in cycle 0, arvalid cycle 1, data_ok with rdata=0xDEADBEEF in cycle 4.
REQ-029 SHALL cover byte write: addr=0x2003, size=0, wdata=0x000000AA; awready delayed 3 cycles, wready immediate -> wstrb=4'b1000, wvalid drops after 1 cycle, awvalid held until handshake, data_ok on bvalid.
REQ-030 SHALL cover back-to-back: a second read with req held high during the rvalid cycle -> addr_ok and data_ok in the same cycle, arvalid for the second address the following cycle.
REQ-031 SHALL cover half write: addr=0x3002, size=1 -> wstrb=4'b1100, awsize=3'b001.
REQ-032 SHALL cover reset during RD_R: after resetn is released, the FSM is in IDLE with arvalid=rready=0, and a late rvalid produces no data_ok.
REQ-033 SHALL cover busy ignore: req asserted during RD_AR -> addr_ok=0, and the latched addr is unchanged.
